// File: rtl/cim_bus_arbiter_pkg.sv
// Shared types and default sizing for the inter-CIM broadcast bus arbiter.
package cim_bus_arbiter_pkg;

  localparam int unsigned CIM_NUM_CIMS  = 64;
  localparam int unsigned CIM_N_STORAGE = 16;
  localparam int unsigned BUS_LEN_W     = 7;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ANNOUNCE,
    BUS_XFER,
    BUS_DONE
  } BUS_ARB_STATE_T;

  // Sender id is wide enough to also encode NUM_CIMS itself.
  function automatic int unsigned sender_id_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cim_bus_arbiter_if.sv
// Request/transfer/broadcast signal bundle between the CIM tiles and the bus arbiter.
interface cim_bus_arbiter_if
  import cim_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CIMS  = CIM_NUM_CIMS,
  parameter int unsigned N_STORAGE = CIM_N_STORAGE,
  parameter int unsigned LEN_W     = BUS_LEN_W
);

  localparam int unsigned IdW = sender_id_w(NUM_CIMS);

  logic [NUM_CIMS-1:0]       req;
  logic [NUM_CIMS*LEN_W-1:0] req_len;
  logic                      tx_valid;
  logic [N_STORAGE-1:0]      tx_data;
  logic [NUM_CIMS-1:0]       gnt;
  logic                      bus_start;
  logic [IdW-1:0]            bus_sender_id;
  logic [LEN_W-1:0]          bus_data_len;
  logic                      bus_valid;
  logic [N_STORAGE-1:0]      bus_data;
  logic                      bus_done;
  logic                      busy;
  logic                      timeout_err;

  // Arbiter side.
  modport master (
    input  req, req_len, tx_valid, tx_data,
    output gnt, bus_start, bus_sender_id, bus_data_len, bus_valid, bus_data, bus_done, busy,
           timeout_err
  );

  // Tile side.
  modport slave (
    output req, req_len, tx_valid, tx_data,
    input  gnt, bus_start, bus_sender_id, bus_data_len, bus_valid, bus_data, bus_done, busy,
           timeout_err
  );

endinterface

// File: rtl/cim_bus_arbiter_rr.sv
// Combinational round-robin picker: lowest set request at or above i_ptr, else lowest overall.
module rr_arbiter #(
  parameter int unsigned N    = 64,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);

  logic [N-1:0] w_masked;
  logic [N-1:0] w_pick;

  // Bits below the pointer are masked off; fall back to the full vector to wrap around.
  assign w_masked = i_req & ~((N'(1) << i_ptr) - N'(1));
  assign w_pick   = (|w_masked) ? w_masked : i_req;
  assign o_gnt    = w_pick & (~w_pick + N'(1));
  assign o_valid  = |i_req;

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (o_gnt[i]) begin
        o_idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/counter.sv
// Generic clearable counter; MODE 0 wraps, any other MODE saturates at all-ones.
module counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_clr) begin
      w_count_next = '0;
    end else if (i_en) begin
      if (MODE == 0 || r_count != '1) begin
        w_count_next = r_count + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cim_bus_arbiter.sv
// Round-robin owner of the inter-CIM broadcast bus: announce, forward data_len words, release.
// Optional idle-transfer watchdog and sticky timeout_err are enabled with `define BUS_TIMEOUT_EN.
module cim_bus_arbiter
  import cim_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CIMS    = CIM_NUM_CIMS,
  parameter int unsigned N_STORAGE   = CIM_N_STORAGE,
`ifdef BUS_TIMEOUT_EN
  parameter int unsigned LEN_W       = BUS_LEN_W,
  parameter int unsigned TIMEOUT_CYC = 255
`else
  parameter int unsigned LEN_W       = BUS_LEN_W
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cim_bus_arbiter_if.master     bus
);

  localparam int unsigned IdxW = (NUM_CIMS > 1) ? $clog2(NUM_CIMS) : 1;
  localparam int unsigned IdW  = sender_id_w(NUM_CIMS);

  BUS_ARB_STATE_T r_state;
  BUS_ARB_STATE_T w_state_next;

  logic [NUM_CIMS-1:0]  r_gnt;
  logic [IdW-1:0]       r_sender_id;
  logic [LEN_W-1:0]     r_data_len;
  logic                 r_bus_valid;
  logic [N_STORAGE-1:0] r_bus_data;
  logic [IdxW-1:0]      r_rr_ptr;

  logic [NUM_CIMS-1:0]  w_rr_gnt;
  logic [IdxW-1:0]      w_rr_idx;
  logic                 w_rr_valid;
  logic [LEN_W-1:0]     w_req_len_sel;
  logic [LEN_W-1:0]     w_count;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_timeout;
  logic [IdxW-1:0]      w_ptr_next;

  rr_arbiter #(
    .N    (NUM_CIMS),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .i_req   (bus.req),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

  counter #(
    .WIDTH (LEN_W),
    .MODE  (0)
  ) u_word_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (r_state == BUS_ANNOUNCE),
    .i_en    (w_accept),
    .o_count (w_count)
  );

  assign w_req_len_sel = bus.req_len[w_rr_idx*LEN_W +: LEN_W];
  assign w_accept      = (r_state == BUS_XFER) && bus.tx_valid;
  assign w_last        = w_accept && (w_count == r_data_len - LEN_W'(1));
  assign w_ptr_next    = (r_sender_id == IdW'(NUM_CIMS - 1)) ? '0
                       : r_sender_id[IdxW-1:0] + IdxW'(1);

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);

  logic [IdleW-1:0] r_idle_cnt;
  logic             r_timeout_err;

  // Fires on the TIMEOUT_CYC-th consecutive XFER cycle without a valid word.
  assign w_timeout = (r_state == BUS_XFER) && !bus.tx_valid
                   && (r_idle_cnt == IdleW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != BUS_XFER || bus.tx_valid) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + IdleW'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      BUS_IDLE:     if (w_rr_valid) w_state_next = BUS_ANNOUNCE;
      BUS_ANNOUNCE: w_state_next = (r_data_len == '0) ? BUS_DONE : BUS_XFER;
      BUS_XFER:     if (w_last || w_timeout) w_state_next = BUS_DONE;
      BUS_DONE:     w_state_next = BUS_IDLE;
      default:      w_state_next = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BUS_IDLE;
      r_gnt       <= '0;
      r_sender_id <= '0;
      r_data_len  <= '0;
      r_bus_valid <= 1'b0;
      r_bus_data  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_bus_valid <= w_accept;
      if (w_accept) begin
        r_bus_data <= bus.tx_data;
      end
      if (r_state == BUS_IDLE && w_rr_valid) begin
        r_gnt       <= w_rr_gnt;
        r_sender_id <= IdW'(w_rr_idx);
        r_data_len  <= w_req_len_sel;
      end else if (r_state == BUS_DONE) begin
        r_gnt       <= '0;
        r_sender_id <= '0;
        r_data_len  <= '0;
        r_rr_ptr    <= w_ptr_next;
      end
    end
  end

  assign bus.gnt           = r_gnt;
  assign bus.bus_start     = (r_state == BUS_ANNOUNCE);
  assign bus.bus_sender_id = r_sender_id;
  assign bus.bus_data_len  = r_data_len;
  assign bus.bus_valid     = r_bus_valid;
  assign bus.bus_data      = r_bus_data;
  assign bus.bus_done      = (r_state == BUS_DONE);
  assign bus.busy          = (r_state != BUS_IDLE);

endmodule
